rv_pipeline_reg: RTL and testbench

- Single-entry valid/ready pipeline register (register slice) that breaks the combinational data/valid path between a producer and a consumer.
- Full throughput: one transfer per cycle when downstream is ready.
- Data is held stable under backpressure.
- Used as the generic stage element in ready/valid datapaths.

---
 rtl/rv_pipeline_reg_pkg.sv | 7 +
 rtl/rv_pipeline_reg.sv | 65 ++++++
 tb/tb_rv_pipeline_reg.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv_pipeline_reg_pkg.sv
// Shared definitions for the ready/valid pipeline register.
// Holds the default payload width used by stage instances.
package rv_pipeline_reg_pkg;

    localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/rv_pipeline_reg.sv
// Single-entry valid/ready register slice.
// Full throughput; payload held stable under backpressure.
module rv_pipeline_reg
    import rv_pipeline_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              full;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              fire;

    // out_ready -> in_ready is the only combinational path
    assign in_ready  = !full || out_ready;
    assign accept    = in_valid && in_ready;
    assign fire      = full && out_ready;
    assign out_valid = full;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
        end else if (fire) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (accept) begin
            data_q <= in_data;
        end
    end

`ifndef SYNTHESIS
    a_data_stable : assert property (
        @(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> $stable(out_data)
    );

    a_valid_held : assert property (
        @(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid
    );

    a_no_accept_blocked : assert property (
        @(posedge clk) disable iff (rst)
        !in_ready |=> $stable(out_data) && out_valid
    );
`endif

endmodule

// File: tb/tb_rv_pipeline_reg.sv
// Directed-vector and model-based bench for rv_pipeline_reg.
// Inputs driven on negedge; outputs sampled #1 after posedge.
module tb_rv_pipeline_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    rv_pipeline_reg #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        chk_rdy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv,
                         input logic [31:0] d, input logic o);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = o;
    endtask

    logic        m_full;
    logic [31:0] m_data;
    logic        m_rdy;

    initial begin
        // rst iv data ordy chk_rdy exp_rdy exp_ov exp_od
        vecs[0]  = '{1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h0,         0, 1, 1, 0, 32'h0};
        vecs[2]  = '{0, 1, 32'hA5A5_0001, 1, 1, 1, 1, 32'hA5A5_0001};
        vecs[3]  = '{0, 0, 32'h0,         1, 1, 1, 0, 32'hA5A5_0001};
        vecs[4]  = '{0, 1, 32'hDEAD_BEEF, 0, 1, 1, 1, 32'hDEAD_BEEF};
        vecs[5]  = '{0, 1, 32'h1111_1111, 0, 1, 0, 1, 32'hDEAD_BEEF};
        vecs[6]  = '{0, 1, 32'h1111_1111, 0, 1, 0, 1, 32'hDEAD_BEEF};
        vecs[7]  = '{0, 1, 32'h1111_1111, 0, 1, 0, 1, 32'hDEAD_BEEF};
        vecs[8]  = '{0, 0, 32'h2222_2222, 1, 1, 1, 0, 32'hDEAD_BEEF};
        vecs[9]  = '{0, 1, 32'h1234_5678, 1, 1, 1, 1, 32'h1234_5678};
        vecs[10] = '{0, 1, 32'hCAFE_F00D, 1, 1, 1, 1, 32'hCAFE_F00D};
        vecs[11] = '{0, 0, 32'h3333_3333, 0, 1, 0, 1, 32'hCAFE_F00D};
        vecs[12] = '{0, 1, 32'hDEAD_BEEF, 1, 1, 1, 1, 32'hDEAD_BEEF};
        vecs[13] = '{0, 1, 32'h4444_4444, 0, 1, 0, 1, 32'hDEAD_BEEF};
        vecs[14] = '{1, 1, 32'h5555_5555, 0, 1, 0, 0, 32'h0};
        vecs[15] = '{0, 0, 32'h6666_6666, 0, 1, 1, 0, 32'h0};
        vecs[16] = '{0, 0, 32'h0,         1, 1, 1, 0, 32'h0};

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
            #1;
            if (vecs[i].chk_rdy)
                check($sformatf("v%0d in_ready", i),
                      {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i),
                  {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
            check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_od);
        end

        // long stall: data must not move for many cycles of new inputs
        drive(0, 1, 32'h0BAD_CAFE, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, $urandom, 0);
            @(posedge clk);
            #1;
            check("stall out_data", out_data, 32'h0BAD_CAFE);
            check("stall out_valid", {31'b0, out_valid}, 32'h1);
        end

        // random traffic against an independent reference model
        drive(1, 0, 32'h0, 0);
        m_full = 1'b0;
        m_data = '0;
        for (int i = 0; i < 200; i++) begin
            drive(0, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)));
            m_rdy = !m_full || out_ready;
            #1;
            check("rand in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
            if (in_valid && m_rdy) begin
                m_full = 1'b1;
                m_data = in_data;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
            @(posedge clk);
            #1;
            check("rand out_valid", {31'b0, out_valid}, {31'b0, m_full});
            check("rand out_data", out_data, m_data);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
